// File: rtl/mem_pkg.sv
// Shared constants, helpers and the response record for the BRAM data-memory controller.
package mem_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_MAX = 64;

    // Sized for the widest legal DATA_W; narrower controllers zero-extend rdata.
    typedef struct packed {
        logic [DATA_W_MAX-1:0] rdata;
        logic                  err;
        logic                  we;
    } resp_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// Synchronous FIFO with wrap-bit pointers; the head entry is visible whenever not empty.
module resp_fifo
    import mem_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int IDX_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [IDX_W:0]   wr_ptr_reg;
    logic [IDX_W:0]   rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    // Index wraps at DEPTH (not 2^IDX_W) so non-power-of-two depths work; MSB toggles on wrap.
    function automatic logic [IDX_W:0] ptr_inc(input logic [IDX_W:0] p);
        if (p[IDX_W-1:0] == IDX_W'(DEPTH - 1)) begin
            return {~p[IDX_W], IDX_W'(0)};
        end
        return {p[IDX_W], p[IDX_W-1:0] + IDX_W'(1)};
    endfunction

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[IDX_W-1:0] == rd_ptr_reg[IDX_W-1:0]) &&
                     (wr_ptr_reg[IDX_W] != rd_ptr_reg[IDX_W]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr_reg[IDX_W-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[IDX_W-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
        end
    end

    overflow_check: assert property (@(posedge clk) disable iff (!rstn) !(push && full))
        else $error("resp_fifo: push into a full FIFO");

endmodule

// File: rtl/bram_mem_ctrl.sv
// Load/store front end for a single-port BRAM: request handshake, address checks,
// read-latency tracking and an in-order buffered response channel.
module bram_mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_LAT     = 1,
    parameter int RESP_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [31:0]         req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                resp_we,
    output logic                bram_en,
    output logic [DATA_W/8-1:0] bram_we,
    output logic [ADDR_W-1:0]   bram_addr,
    output logic [DATA_W-1:0]   bram_din,
    input  logic [DATA_W-1:0]   bram_dout
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF    = clog2(STRB_W);
    localparam int HI_LSB = ADDR_W + OFF;
    localparam int CNT_W  = clog2(RESP_DEPTH + 1) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RESP_DEPTH);

    genvar gi;

    generate
        if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
            $error("bram_mem_ctrl: DATA_W must be 32 or 64");
        end
        if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
            $error("bram_mem_ctrl: RD_LAT must be in 1..3");
        end
        if (RESP_DEPTH < RD_LAT + 1) begin : g_bad_depth
            $error("bram_mem_ctrl: RESP_DEPTH must be at least RD_LAT+1");
        end
    endgenerate

    logic             req_ready_reg;
    logic             accept;
    logic             addr_misaligned;
    logic             addr_oor;
    logic             req_err;
    logic [CNT_W-1:0] outstanding_reg;
    logic [CNT_W-1:0] outstanding_next;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    resp_t            push_resp;
    resp_t            head;
    logic [$bits(resp_t)-1:0] fifo_dout;
    logic             unused_head_bits;

    assign req_ready       = req_ready_reg;
    assign accept          = req_valid && req_ready_reg;
    assign addr_misaligned = |req_addr[OFF-1:0];
    assign addr_oor        = |(req_addr >> HI_LSB);
    assign req_err         = addr_misaligned || addr_oor;

    // BRAM is driven in the accept cycle; erroring requests never reach it.
    assign bram_en   = accept && !req_err;
    assign bram_we   = (bram_en && req_we) ? req_wstrb : '0;
    assign bram_addr = ADDR_W'(req_addr >> OFF);
    assign bram_din  = req_wdata;

    // Every accepted request (errors included) walks the pipe so responses stay ordered.
    for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
        logic valid_reg, err_reg, we_reg;
        logic valid_in, err_in, we_in;
        if (gi == 0) begin : g_src
            assign valid_in = accept;
            assign err_in   = req_err;
            assign we_in    = req_we;
        end else begin : g_src
            assign valid_in = g_stage[gi-1].valid_reg;
            assign err_in   = g_stage[gi-1].err_reg;
            assign we_in    = g_stage[gi-1].we_reg;
        end
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                valid_reg <= 1'b0;
                err_reg   <= 1'b0;
                we_reg    <= 1'b0;
            end else begin
                valid_reg <= valid_in;
                err_reg   <= err_in;
                we_reg    <= we_in;
            end
        end
    end

    assign push = g_stage[RD_LAT-1].valid_reg;

    always_comb begin
        push_resp       = '0;
        push_resp.err   = g_stage[RD_LAT-1].err_reg;
        push_resp.we    = g_stage[RD_LAT-1].we_reg;
        if (!g_stage[RD_LAT-1].err_reg && !g_stage[RD_LAT-1].we_reg) begin
            push_resp.rdata = DATA_W_MAX'(bram_dout);
        end
    end

    resp_fifo #(
        .WIDTH ($bits(resp_t)),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .din   (push_resp),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head             = resp_t'(fifo_dout);
    assign unused_head_bits = ^head;
    assign pop              = !fifo_empty && resp_ready;
    assign resp_valid       = !fifo_empty;
    assign resp_rdata       = fifo_empty ? '0 : head.rdata[DATA_W-1:0];
    assign resp_err         = !fifo_empty && head.err;
    assign resp_we          = !fifo_empty && head.we;

    always_comb begin
        outstanding_next = outstanding_reg;
        if (accept && !pop) begin
            outstanding_next = outstanding_reg + CNT_W'(1);
        end else if (!accept && pop) begin
            outstanding_next = outstanding_reg - CNT_W'(1);
        end
    end

    // Ready is registered from the next occupancy, so it never depends on resp_ready combinationally.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            outstanding_reg <= '0;
            req_ready_reg   <= 1'b0;
        end else begin
            outstanding_reg <= outstanding_next;
            req_ready_reg   <= (outstanding_next < DEPTH_CNT);
        end
    end

endmodule

// File: tb/tb_bram_mem_ctrl.sv
// Randomised bench for bram_mem_ctrl with a word-level memory model and ordered response queue.
module tb_bram_mem_ctrl;

    localparam int ADDR_W     = 20;
    localparam int DATA_W     = 32;
    localparam int RD_LAT     = 2;
    localparam int RESP_DEPTH = 4;
    localparam longint MEM_BYTES = longint'(1) << (ADDR_W + 2);

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        we;
        int          cyc;
    } rsp_t;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [31:0]       req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic [3:0]        req_wstrb = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b1;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              resp_we;
    logic              bram_en;
    logic [3:0]        bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [31:0]       bram_din;
    logic [31:0]       bram_dout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bram_mem_ctrl #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RD_LAT     (RD_LAT),
        .RESP_DEPTH (RESP_DEPTH)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .resp_we    (resp_we),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_din   (bram_din),
        .bram_dout  (bram_dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM stand-in: read-first, byte-enable writes, RD_LAT-cycle read data.
    logic [31:0] bmem [int];
    logic [31:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        logic [31:0] w;
        for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        if (bram_en) begin
            w = bmem.exists(int'(bram_addr)) ? bmem[int'(bram_addr)] : 32'h0;
            rd_pipe[0] <= w;
            for (int b = 0; b < 4; b++) if (bram_we[b]) w[8*b +: 8] = bram_din[8*b +: 8];
            bmem[int'(bram_addr)] = w;
        end
    end
    assign bram_dout = rd_pipe[RD_LAT-1];

    // Response recorder; also notes any payload change while stalled.
    rsp_t        obs_q[$];
    int          stab_viol = 0;
    logic        held = 1'b0;
    logic [33:0] held_pay;
    always @(negedge clk) begin
        rsp_t o;
        if (rstn && resp_valid) begin
            if (held && {resp_rdata, resp_err, resp_we} !== held_pay) stab_viol++;
            if (resp_ready) begin
                o.rdata = resp_rdata; o.err = resp_err; o.we = resp_we; o.cyc = cyc;
                obs_q.push_back(o);
            end
            held     = !resp_ready;
            held_pay = {resp_rdata, resp_err, resp_we};
        end else begin
            held = 1'b0;
        end
    end

    // Reference model: byte-addressed rules applied to a word dictionary.
    logic [31:0] ref_mem [int];
    rsp_t        exp_q[$];

    function automatic logic model_accept(input logic we, input logic [31:0] addr,
                                          input logic [31:0] wd, input logic [3:0] st);
        rsp_t e;
        logic [31:0] cur;
        int widx;
        e.we = we; e.rdata = 32'h0; e.cyc = cyc;
        e.err = (addr % 4 != 0) || (64'(addr) >= 64'(MEM_BYTES));
        if (!e.err) begin
            widx = int'(addr / 4);
            cur = ref_mem.exists(widx) ? ref_mem[widx] : 32'h0;
            if (we) begin
                for (int b = 0; b < 4; b++) if (st[b]) cur[8*b +: 8] = wd[8*b +: 8];
                ref_mem[widx] = cur;
            end else begin
                e.rdata = cur;
            end
        end
        exp_q.push_back(e);
        return e.err;
    endfunction

    // Called and returns at posedge+1; holds the request until accepted (bounded).
    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, output int waits, output logic en_seen);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = st;
        waits = 0;
        @(negedge clk);
        while (!req_ready && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        en_seen = bram_en;
        if (req_ready) begin
            void'(model_accept(we, addr, wd, st));
        end else begin
            checks++; errors++;
            $display("FAIL send_timeout addr=%h ready=%b required ready=1", addr, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && obs_q.size() < exp_q.size(); i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        #12;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b want 0", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
        checks++; if ({resp_rdata, resp_err, resp_we} !== 34'h0) begin errors++; $display("FAIL rst_payload got %h/%b/%b want 0/0/0", resp_rdata, resp_err, resp_we); end
        checks++; if (bram_en !== 1'b0 || bram_we !== 4'h0) begin errors++; $display("FAIL rst_bram got en=%b we=%h want 0/0", bram_en, bram_we); end
        @(posedge clk); #1; rstn = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_release_early got %b want 0", req_ready); end
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b want 1", req_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        int base, w; logic en0, en1;
        base = exp_q.size();
        send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, w, en0);
        send(1'b0, 32'h10, 32'h0, 4'h0, w, en1);
        drain();
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL wr_rd_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        else begin
            checks++; if (obs_q[base].rdata !== 32'h0 || obs_q[base].err !== 1'b0 || obs_q[base].we !== 1'b1) begin errors++; $display("FAIL wr_resp got %h/%b/%b want 0/0/1", obs_q[base].rdata, obs_q[base].err, obs_q[base].we); end
            checks++; if (obs_q[base+1].rdata !== 32'hDEADBEEF || obs_q[base+1].err !== 1'b0) begin errors++; $display("FAIL rd_resp got %h err=%b want deadbeef err=0", obs_q[base+1].rdata, obs_q[base+1].err); end
            checks++; if (obs_q[base+1].cyc !== exp_q[base+1].cyc + RD_LAT + 1) begin errors++; $display("FAIL rd_latency got %0d want %0d", obs_q[base+1].cyc - exp_q[base+1].cyc, RD_LAT + 1); end
        end
        checks++; if (en0 !== 1'b1 || en1 !== 1'b1) begin errors++; $display("FAIL wr_rd_bram_en got %b%b want 11", en0, en1); end
    endtask

    task automatic test_strobe();
        int base, w; logic en;
        base = exp_q.size();
        send(1'b1, 32'h10, 32'h000000AA, 4'h1, w, en);
        send(1'b0, 32'h10, 32'h0, 4'h0, w, en);
        send(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, w, en);
        send(1'b0, 32'h10, 32'h0, 4'h0, w, en);
        drain();
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL strobe_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        else begin
            checks++; if (obs_q[base+1].rdata !== 32'hDEADBEAA) begin errors++; $display("FAIL strobe_byte0 got %h want deadbeaa", obs_q[base+1].rdata); end
            checks++; if (obs_q[base+3].rdata !== 32'hDEADBEAA) begin errors++; $display("FAIL strobe_zero got %h want deadbeaa", obs_q[base+3].rdata); end
            for (int i = base; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i].rdata !== exp_q[i].rdata || obs_q[i].err !== exp_q[i].err || obs_q[i].we !== exp_q[i].we) begin
                    errors++; $display("FAIL strobe_resp[%0d] got %h/%b/%b want %h/%b/%b", i, obs_q[i].rdata, obs_q[i].err, obs_q[i].we, exp_q[i].rdata, exp_q[i].err, exp_q[i].we);
                end
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [4];
        logic en [4];
        int base, w;
        addrs[0] = 32'h10; addrs[1] = 32'h12; addrs[2] = 32'h0040_0000; addrs[3] = 32'h10;
        base = exp_q.size();
        for (int i = 0; i < 4; i++) send(1'b0, addrs[i], 32'h0, 4'h0, w, en[i]);
        drain();
        checks++; if ({en[0], en[1], en[2], en[3]} !== 4'b1001) begin errors++; $display("FAIL err_bram_en got %b%b%b%b want 1001", en[0], en[1], en[2], en[3]); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL err_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        else begin
            checks++;
            if ({obs_q[base].err, obs_q[base+1].err, obs_q[base+2].err, obs_q[base+3].err} !== 4'b0110) begin
                errors++; $display("FAIL err_order got %b%b%b%b want 0110", obs_q[base].err, obs_q[base+1].err, obs_q[base+2].err, obs_q[base+3].err);
            end
            for (int i = base; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i].rdata !== exp_q[i].rdata || obs_q[i].err !== exp_q[i].err || obs_q[i].we !== exp_q[i].we) begin
                    errors++; $display("FAIL err_resp[%0d] got %h/%b/%b want %h/%b/%b", i, obs_q[i].rdata, obs_q[i].err, obs_q[i].we, exp_q[i].rdata, exp_q[i].err, exp_q[i].we);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int base, acc;
        base = exp_q.size(); acc = 0;
        resp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_wstrb = 4'h0;
        req_addr = 32'($urandom_range(0, 15)) << 2;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (req_ready) begin void'(model_accept(1'b0, req_addr, 32'h0, 4'h0)); acc++; end
            @(posedge clk); #1;
            req_addr = 32'($urandom_range(0, 15)) << 2;
        end
        checks++; if (acc !== RESP_DEPTH) begin errors++; $display("FAIL bp_accepted got %0d want %0d", acc, RESP_DEPTH); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low got %b want 0", req_ready); end
        req_valid = 1'b0; resp_ready = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_first_pop got %b want 0", req_ready); end
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop got %b want 1", req_ready); end
        @(posedge clk); #1;
        drain();
        checks++; if (stab_viol !== 0) begin errors++; $display("FAIL bp_stability got %0d changes want 0", stab_viol); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        else for (int i = base; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].rdata !== exp_q[i].rdata || obs_q[i].err !== exp_q[i].err || obs_q[i].we !== exp_q[i].we) begin
                errors++; $display("FAIL bp_resp[%0d] got %h/%b/%b want %h/%b/%b", i, obs_q[i].rdata, obs_q[i].err, obs_q[i].we, exp_q[i].rdata, exp_q[i].err, exp_q[i].we);
            end
        end
    endtask

    task automatic test_back_to_back();
        int wb, w, base;
        logic en;
        wb = int'($urandom_range(0, 1000));
        resp_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(1'b1, 32'((wb + i) * 4), $urandom, 4'($urandom_range(0, 15)), w, en);
        base = exp_q.size();
        for (int i = 0; i < 8; i++) begin
            send(1'b0, 32'((wb + i) * 4), 32'h0, 4'h0, w, en);
            checks++; if (w !== 0) begin errors++; $display("FAIL b2b_ready[%0d] got %0d stall cycles want 0", i, w); end
        end
        drain();
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        else for (int i = base; i < base + 8; i++) begin
            checks++;
            if (obs_q[i].rdata !== exp_q[i].rdata || obs_q[i].err !== exp_q[i].err || obs_q[i].cyc !== exp_q[i].cyc + RD_LAT + 1) begin
                errors++; $display("FAIL b2b_resp[%0d] got %h err=%b lat=%0d want %h err=%b lat=%0d", i, obs_q[i].rdata, obs_q[i].err, obs_q[i].cyc - exp_q[i].cyc, exp_q[i].rdata, exp_q[i].err, RD_LAT + 1);
            end
        end
    endtask

    task automatic test_random();
        int base, sel;
        logic e;
        base = exp_q.size();
        for (int c = 0; c < 120; c++) begin
            sel = int'($urandom_range(0, 9));
            req_valid  = ($urandom_range(0, 3) != 0);
            req_we     = 1'($urandom_range(0, 1));
            req_wdata  = $urandom;
            req_wstrb  = 4'($urandom_range(0, 15));
            resp_ready = ($urandom_range(0, 2) != 0);
            if (sel == 0)      req_addr = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(1, 3));
            else if (sel == 1) req_addr = 32'h0040_0000 + (32'($urandom_range(0, 255)) << 2);
            else               req_addr = 32'($urandom_range(0, 31)) << 2;
            @(negedge clk);
            checks++;
            if (req_valid && req_ready) begin
                e = model_accept(req_we, req_addr, req_wdata, req_wstrb);
                if (bram_en !== !e || (!e && (bram_addr !== ADDR_W'(req_addr >> 2) || bram_we !== (req_we ? req_wstrb : 4'h0)))) begin
                    errors++; $display("FAIL rnd_bram[%0d] got en=%b addr=%h we=%h want en=%b addr=%h", c, bram_en, bram_addr, bram_we, !e, ADDR_W'(req_addr >> 2));
                end
            end else if (bram_en !== 1'b0) begin
                errors++; $display("FAIL rnd_idle_en[%0d] got %b want 0", c, bram_en);
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        drain();
        checks++; if (stab_viol !== 0) begin errors++; $display("FAIL rnd_stability got %0d changes want 0", stab_viol); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        else for (int i = base; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].rdata !== exp_q[i].rdata || obs_q[i].err !== exp_q[i].err || obs_q[i].we !== exp_q[i].we) begin
                errors++; $display("FAIL rnd_resp[%0d] got %h/%b/%b want %h/%b/%b", i, obs_q[i].rdata, obs_q[i].err, obs_q[i].we, exp_q[i].rdata, exp_q[i].err, exp_q[i].we);
            end
        end
    endtask

    task automatic test_reset_midop();
        int w, seen, nobs;
        logic en;
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(1'b0, 32'(i * 4), 32'h0, 4'h0, w, en);
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid got %b want 1", resp_valid); end
        rstn = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", resp_valid); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b want 0", req_ready); end
        while (exp_q.size() > obs_q.size()) exp_q.pop_back();
        nobs = obs_q.size();
        resp_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL midrst_release_early got %b want 0", req_ready); end
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_release_ready got %b want 1", req_ready); end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        checks++; if (seen !== 0 || obs_q.size() != nobs) begin errors++; $display("FAIL midrst_stale got %0d valid cycles want 0", seen); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_strobe();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
